// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard_unit_mc slice.
package hazard_pkg;

  // Operand source select driven into the E-stage ALU input muxes
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // Data-memory wait tracker states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    TMO  = 2'b10
  } mem_fsm_e;

  // Architectural zero register index (x0 never forwards or creates hazards)
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_mem_wait.sv
// hazard_mem_wait: tracks how long a data-memory access in M has been waiting
// and raises a sticky timeout flag once the wait exceeds MEM_TIMEOUT cycles.
//
// state | meaning
// IDLE  | no access outstanding, or access completed
// WAIT  | access stalled, counting wait cycles
// TMO   | wait limit exceeded; stall continues until ready
module hazard_mem_wait
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_mem_stall,
  input  logic i_mem_ready,
  output logic o_timeout
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  mem_fsm_e          r_state;
  mem_fsm_e          w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;

  // State, wait counter and sticky flag registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic; the counter stops at the limit so it never wraps
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      IDLE: begin
        if (i_mem_stall) begin
          w_state_nxt = WAIT;
          w_wcnt_nxt  = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (i_mem_ready) begin
          w_state_nxt = IDLE;
          w_wcnt_nxt  = '0;
        end else if (r_wcnt == WCNT_LAST) begin
          w_state_nxt   = TMO;
          w_wcnt_nxt    = r_wcnt + 1'b1;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
      end
      TMO: begin
        if (i_mem_ready) begin
          w_state_nxt = IDLE;
          w_wcnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // Outputs are taken straight from registers to keep them glitch-free
  always_comb begin
    o_timeout = r_timeout;
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use stall, branch flush and data-memory
// wait freeze for the 5-stage RV32I pipeline.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] Rs1D_i,
  input  logic [REG_AW-1:0] Rs2D_i,
  input  logic [REG_AW-1:0] Rs1E_i,
  input  logic [REG_AW-1:0] Rs2E_i,
  input  logic [REG_AW-1:0] RdE_i,
  input  logic [REG_AW-1:0] RdM_i,
  input  logic [REG_AW-1:0] RdW_i,
  input  logic              RegWriteM_i,
  input  logic              RegWriteW_i,
  input  logic              MemReadE_i,
  input  logic              PCSrcE_i,
  input  logic              MemReqM_i,
  input  logic              MemReadyM_i,
  output logic [1:0]        ForwardAE_o,
  output logic [1:0]        ForwardBE_o,
  output logic              PCen_o,
  output logic              Fen_o,
  output logic              Den_o,
  output logic              Een_o,
  output logic              Men_o,
  output logic              Drst_o,
  output logic              Erst_o,
  output logic              Wrst_o,
  output logic              MemTimeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  StallCnt_o,
  output logic [CNT_W-1:0]  FlushCnt_o
`endif
);

  localparam logic [REG_AW-1:0] W_ZERO = REG_AW'(REG_ZERO);

  fwd_sel_e w_fwd_a;
  fwd_sel_e w_fwd_b;
  logic     w_lw_stall;
  logic     w_mem_stall;
  logic     w_timeout;

  assign w_mem_stall = MemReqM_i & ~MemReadyM_i;
  assign w_lw_stall  = MemReadE_i && (RdE_i != W_ZERO) &&
                       ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  // Operand forwarding: the younger result in M wins over W
  always_comb begin
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (RegWriteM_i && (RdM_i != W_ZERO) && (RdM_i == Rs1E_i))
      w_fwd_a = FWD_M;
    else if (RegWriteW_i && (RdW_i != W_ZERO) && (RdW_i == Rs1E_i))
      w_fwd_a = FWD_W;
    if (RegWriteM_i && (RdM_i != W_ZERO) && (RdM_i == Rs2E_i))
      w_fwd_b = FWD_M;
    else if (RegWriteW_i && (RdW_i != W_ZERO) && (RdW_i == Rs2E_i))
      w_fwd_b = FWD_W;
  end

  // Stage control priority: reset, memory freeze, branch flush, load-use stall.
  // A frozen E keeps its inputs, so branch/lwStall re-evaluate on release.
  always_comb begin
    ForwardAE_o = w_fwd_a;
    ForwardBE_o = w_fwd_b;
    PCen_o      = 1'b1;
    Fen_o       = 1'b1;
    Den_o       = 1'b1;
    Een_o       = 1'b1;
    Men_o       = 1'b1;
    Drst_o      = 1'b0;
    Erst_o      = 1'b0;
    Wrst_o      = 1'b0;
    if (!rst_ni) begin
      ForwardAE_o = FWD_RF;
      ForwardBE_o = FWD_RF;
      Drst_o      = 1'b1;
      Erst_o      = 1'b1;
      Wrst_o      = 1'b1;
    end else if (w_mem_stall) begin
      PCen_o = 1'b0;
      Fen_o  = 1'b0;
      Den_o  = 1'b0;
      Een_o  = 1'b0;
      Men_o  = 1'b0;
      Wrst_o = 1'b1;
    end else if (PCSrcE_i) begin
      Drst_o = 1'b1;
      Erst_o = 1'b1;
    end else if (w_lw_stall) begin
      PCen_o = 1'b0;
      Fen_o  = 1'b0;
      Den_o  = 1'b0;
      Erst_o = 1'b1;
    end
  end

  hazard_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_mem_stall(w_mem_stall),
    .i_mem_ready(MemReadyM_i),
    .o_timeout  (w_timeout)
  );

  assign MemTimeout_o = w_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_evt;
  logic             w_flush_evt;

  assign w_stall_evt = w_mem_stall | (w_lw_stall & ~PCSrcE_i);
  assign w_flush_evt = PCSrcE_i & ~w_mem_stall;

  // Saturating event counters, cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign StallCnt_o = r_stall_cnt;
  assign FlushCnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: scoreboard bench for hazard_unit_mc (MEM_TIMEOUT=4).
// Build with HAZARD_PERF_CNT_EN defined to also check the perf counters.
module tb_hazard_unit_mc;

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_LW   = 5'b00011;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_LW   = 3'b010;
  localparam logic [2:0] FL_BR   = 3'b110;
  localparam logic [2:0] FL_MEM  = 3'b001;
  localparam logic [2:0] FL_RST  = 3'b111;

  logic       clk;
  logic       rst_ni;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MemReadE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       PCen, Fen, Den, Een, Men, Drst, Erst, Wrst, MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  string       q_tag[$];
  logic [12:0] q_exp[$];

  hazard_unit_mc #(
    .REG_AW(5), .MEM_TIMEOUT(4), .CNT_W(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
    .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .MemReadE_i(MemReadE), .PCSrcE_i(PCSrcE),
    .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
    .ForwardAE_o(ForwardAE), .ForwardBE_o(ForwardBE),
    .PCen_o(PCen), .Fen_o(Fen), .Den_o(Den), .Een_o(Een), .Men_o(Men),
    .Drst_o(Drst), .Erst_o(Erst), .Wrst_o(Wrst),
    .MemTimeout_o(MemTimeout)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt_o(stall_cnt), .FlushCnt_o(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [4:0] en, input logic [2:0] fl,
                                     input logic tmo);
    return {fa, fb, en, fl, tmo};
  endfunction

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; MemReadE = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  // Inputs for this cycle are already applied; queue the expectation and advance
  task automatic cyc(input string tag, input logic [12:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs mid-cycle against the oldest queued expectation
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      string       t;
      logic [12:0] e;
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      chk_eq(t, {19'b0, ForwardAE, ForwardBE, PCen, Fen, Den, Een, Men,
                 Drst, Erst, Wrst, MemTimeout}, {19'b0, e});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;

    // reset forcing, even with hazards and a memory stall on the inputs
    cyc("rst_idle", ev(2'b00, 2'b00, EN_ALL, FL_RST, 1'b0));
    MemReqM = 1; MemReadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
    RdM = 5; RegWriteM = 1; Rs1E = 5;
    cyc("rst_forced", ev(2'b00, 2'b00, EN_ALL, FL_RST, 1'b0));
    rst_ni = 1'b1; clr();
    cyc("idle", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));

    // forwarding
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    cyc("fwd_a_m_prio", ev(2'b10, 2'b00, EN_ALL, FL_NONE, 1'b0));
    RdM = 0;
    cyc("fwd_a_w_rdm0", ev(2'b01, 2'b00, EN_ALL, FL_NONE, 1'b0));
    RdM = 5; RegWriteW = 0; Rs1E = 3; Rs2E = 5;
    cyc("fwd_b_m", ev(2'b00, 2'b10, EN_ALL, FL_NONE, 1'b0));
    RdM = 9; RegWriteW = 1; Rs1E = 9;
    cyc("fwd_a_m_b_w", ev(2'b10, 2'b01, EN_ALL, FL_NONE, 1'b0));
    RdM = 5; RegWriteM = 0; RdW = 9;
    cyc("fwd_m_nowrite", ev(2'b01, 2'b00, EN_ALL, FL_NONE, 1'b0));
    RdM = 0; RegWriteM = 1; RdW = 0; Rs1E = 0; Rs2E = 0;
    cyc("fwd_x0", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));
    clr();

    // load-use stall
    MemReadE = 1; RdE = 7; Rs2D = 7;
    cyc("lw_stall", ev(2'b00, 2'b00, EN_LW, FL_LW, 1'b0));
    clr();
    cyc("lw_release", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));
    MemReadE = 1; RdE = 0; Rs1D = 0;
    cyc("lw_x0", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));
    MemReadE = 0; RdE = 7; Rs1D = 7;
    cyc("lw_not_load", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));
    clr();

    // branch beats lwStall
    MemReadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
    cyc("br_over_lw", ev(2'b00, 2'b00, EN_ALL, FL_BR, 1'b0));
    clr();
    cyc("br_release", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));

    // memory wait of 3 cycles with lw+branch pending in E, then release
    MemReqM = 1; MemReadyM = 0; MemReadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
    for (int i = 0; i < 3; i++)
      cyc("mem_wait3", ev(2'b00, 2'b00, EN_NONE, FL_MEM, 1'b0));
    MemReadyM = 1;
    cyc("mem_release_br", ev(2'b00, 2'b00, EN_ALL, FL_BR, 1'b0));
    clr();
    cyc("mem_after", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));

    // timeout: flag visible after 4 stalled cycles (1 IDLE + 3 WAIT)
    MemReqM = 1;
    for (int i = 1; i <= 10; i++)
      cyc("tmo_wait", ev(2'b00, 2'b00, EN_NONE, FL_MEM, (i >= 5)));
    MemReadyM = 1;
    cyc("tmo_ready", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b1));
    clr();
    cyc("tmo_sticky", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b1));
    rst_ni = 1'b0;
    cyc("tmo_rst_cycle", ev(2'b00, 2'b00, EN_ALL, FL_RST, 1'b1));
    rst_ni = 1'b1;
    cyc("tmo_cleared", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));

    // reset in the middle of WAIT must restart the wait count
    MemReqM = 1;
    for (int i = 0; i < 3; i++)
      cyc("midw_wait", ev(2'b00, 2'b00, EN_NONE, FL_MEM, 1'b0));
    rst_ni = 1'b0;
    cyc("midw_rst", ev(2'b00, 2'b00, EN_ALL, FL_RST, 1'b0));
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("midw_rewait", ev(2'b00, 2'b00, EN_NONE, FL_MEM, 1'b0));
    MemReadyM = 1;
    cyc("midw_ready", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));
    clr();
    cyc("midw_idle", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));

    // counter segment: 2 lwStalls, 5 memStall cycles, 3 branches
    rst_ni = 1'b0;
    cyc("perf_rst", ev(2'b00, 2'b00, EN_ALL, FL_RST, 1'b0));
    rst_ni = 1'b1;
    for (int i = 0; i < 2; i++) begin
      MemReadE = 1; RdE = 3; Rs1D = 3;
      cyc("perf_lw", ev(2'b00, 2'b00, EN_LW, FL_LW, 1'b0));
      clr();
      cyc("perf_lw_gap", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));
    end
    MemReqM = 1;
    for (int i = 0; i < 3; i++)
      cyc("perf_mem_a", ev(2'b00, 2'b00, EN_NONE, FL_MEM, 1'b0));
    MemReadyM = 1;
    cyc("perf_mem_a_rdy", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));
    MemReadyM = 0;
    for (int i = 0; i < 2; i++)
      cyc("perf_mem_b", ev(2'b00, 2'b00, EN_NONE, FL_MEM, 1'b0));
    MemReadyM = 1;
    cyc("perf_mem_b_rdy", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));
    clr();
    for (int i = 0; i < 3; i++) begin
      PCSrcE = 1;
      cyc("perf_br", ev(2'b00, 2'b00, EN_ALL, FL_BR, 1'b0));
      clr();
      cyc("perf_br_gap", ev(2'b00, 2'b00, EN_ALL, FL_NONE, 1'b0));
    end
`ifdef HAZARD_PERF_CNT_EN
    chk_eq("stall_cnt", stall_cnt, 32'd7);
    chk_eq("flush_cnt", flush_cnt, 32'd3);
`endif

    chk_eq("sb_drained", q_exp.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
